instr_fetch_queue: RTL and testbench
====================================

// Module: instr_fetch_queue
// PURPOSE
//  Registered instruction queue between the fetch unit and the decoder. It
//  buffers {PC, instruction} pairs with a valid/ready handshake on both sides,
//  so fetch keeps running while decode stalls. It pre-splits the rs/rt/rd and
//  immediate fields for the decoder. It also flags address errors (AdEL) on fetch.
// PARAMETERS
//  DEPTH  4  queue entries; power of two, >= 2
//  AW     2  log2(DEPTH); pointer width
// PORTS
//  clk        in   1   clock; all state updates on posedge
//  reset      in   1   synchronous, active-high; empties queue
//  flush      in   1   synchronous redirect (branch/jump/exception); empties queue
//  in_valid   in   1   fetch presents a valid pair
//  in_ready   out  1   queue accepts a pair this cycle
//  in_pc      in   32  PC of the fetched word
//  in_instr   in   32  fetched instruction word
//  out_valid  out  1   head entry valid
//  out_ready  in   1   decoder consumes head this cycle
//  out_pc     out  32  head PC
//  out_instr  out  32  head instruction
//  out_rs     out  5   out_instr[25:21]
//  out_rt     out  5   out_instr[20:16]
//  out_rd     out  5   out_instr[15:11]
//  out_imm16  out  16  out_instr[15:0]
//  out_imm26  out  26  out_instr[25:0]
//  out_adel   out  1   head entry carries an instruction-fetch address error
//  count      out  AW+1  number of occupied entries, 0..DEPTH
// BEHAVIOUR
//  - State is wr_ptr and rd_ptr (AW bits each, wrap modulo DEPTH) plus a count
//    register (AW+1 bits). Storage is DEPTH x {pc[31:0], instr[31:0], adel}.
//  - Reset value: ptrs=0, count=0, so out_valid=0 and in_ready=1. While
//    out_valid=0, out_pc, out_instr, the split fields and out_adel are all 0.
//  - in_ready = (count != DEPTH). It is registered-state only; there is no
//    combinational path from out_ready to in_ready.
//  - out_valid = (count != 0). Head fields are read combinationally from
//    storage[rd_ptr] (first-word fall-through).
//  - push = in_valid & in_ready. It writes storage[wr_ptr] and increments wr_ptr.
//  - pop = out_valid & out_ready. It increments rd_ptr.
//  - count' = count + push - pop. A simultaneous push and pop leaves count unchanged.
//  - Latency: a pair pushed in cycle N is visible at the head in cycle N+1
//    at the earliest. There is no same-cycle bypass when empty.
//  - Full: in_ready=0, so a pop in that cycle does not enable a push in the same cycle.
//  - Empty: pop is impossible (out_valid=0). out_ready is ignored.
//  - AdEL: adel = (in_pc[1:0] != 0) | (in_pc[31:14] != 0), i.e. the PC is
//    misaligned or beyond the 4096-word instruction ROM. When adel=1 the stored
//    instr is forced to 32'h0 (nop); the stored pc is kept as-is.
//  - Priority: reset > flush > push/pop. On flush, next cycle ptrs=0 and
//    count=0. A push or pop in the flush cycle is discarded. Storage contents
//    are not cleared (they are don't-care).
//  - Reset mid-operation: same result as flush. All entries are lost and the
//    reset values hold from the next cycle.
// TESTING
//  1 Fill: out_ready=0, push pc 0x0,0x4,0x8,0xC -> in_ready=0 after 4th, count=4;
//    then out_ready=1 -> pops in order 0x0..0xC, count 4->0, out_valid=0 after.
//  2 Steady flow: count=2, push+pop same cycle for 8 cycles -> count stays 2;
//    FIFO order holds across pointer wrap (>=10 entries total).
//  3 Full+pop: count=4, in_valid=1, out_ready=1 -> push refused, count=3 next,
//    in_ready=1 next cycle.
//  4 Flush: count=3, flush=1 with in_valid=1, out_ready=1 -> next cycle count=0,
//    out_valid=0, out_pc=0; the pushed pair never appears.
//  5 AdEL: push pc=0x6 instr=0x8C010000 -> head out_adel=1, out_instr=0, out_pc=0x6;
//    push pc=0x10000 -> out_adel=1; push pc=0x3FFC -> out_adel=0.
//  6 Reset mid-stream: count=2, reset=1 for 1 cycle -> count=0, in_ready=1;
//    next push of 0x20 pops first, with out_rs/rt/rd matching the instr fields.

Source files
------------

// File: rtl/instr_fetch_queue.sv
// rtl/instr_fetch_queue.sv - registered fetch-to-decode instruction queue
//
// Buffers {pc, instr, adel} entries between fetch and decode with a
// valid/ready handshake on each side. The head is presented first-word
// fall-through, with the rs/rt/rd/imm fields pre-split for the decoder.
//
// Ports:
//   clk        clock, all state changes on posedge
//   reset      synchronous active-high, empties the queue
//   flush      synchronous redirect, empties the queue
//   in_valid   fetch presents a pair       in_ready   queue can accept
//   in_pc      fetched PC                  in_instr   fetched word
//   out_valid  head entry valid            out_ready  decoder consumes head
//   out_pc     head PC                     out_instr  head instruction
//   out_rs/rt/rd/imm16/imm26  head instruction fields
//   out_adel   head entry had an instruction-fetch address error
//   count      occupied entries, 0..DEPTH
module instr_fetch_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_pc,
  input  logic [31:0]   in_instr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_pc,
  output logic [31:0]   out_instr,
  output logic [4:0]    out_rs,
  output logic [4:0]    out_rt,
  output logic [4:0]    out_rd,
  output logic [15:0]   out_imm16,
  output logic [25:0]   out_imm26,
  output logic          out_adel,
  output logic [AW:0]   count
);

  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [31:0] pc_mem    [DEPTH];
  logic [31:0] instr_mem [DEPTH];
  logic        adel_mem  [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  logic          in_adel;

  // Ready/valid come only from the count register, so there is no
  // combinational path from out_ready to in_ready.
  assign in_ready  = (count != FULL_COUNT);
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Misaligned PC or beyond the 4096-word instruction ROM.
  assign in_adel = (in_pc[1:0] != 2'b00) | (in_pc[31:14] != 18'd0);

  // Storage is never cleared; stale entries are masked by out_valid.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= in_pc;
      instr_mem[wr_ptr] <= in_adel ? 32'h0 : in_instr;
      adel_mem[wr_ptr]  <= in_adel;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    out_pc    = 32'h0;
    out_instr = 32'h0;
    out_adel  = 1'b0;
    if (out_valid) begin
      out_pc    = pc_mem[rd_ptr];
      out_instr = instr_mem[rd_ptr];
      out_adel  = adel_mem[rd_ptr];
    end
  end

  assign out_rs    = out_instr[25:21];
  assign out_rt    = out_instr[20:16];
  assign out_rd    = out_instr[15:11];
  assign out_imm16 = out_instr[15:0];
  assign out_imm26 = out_instr[25:0];

endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb/tb_instr_fetch_queue.sv - directed self-checking bench for instr_fetch_queue
module tb_instr_fetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [4:0]  out_rs;
  logic [4:0]  out_rt;
  logic [4:0]  out_rd;
  logic [15:0] out_imm16;
  logic [25:0] out_imm26;
  logic        out_adel;
  logic [2:0]  count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  instr_fetch_queue #(.DEPTH(4), .AW(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_instr (out_instr),
    .out_rs    (out_rs),
    .out_rt    (out_rt),
    .out_rd    (out_rd),
    .out_imm16 (out_imm16),
    .out_imm26 (out_imm26),
    .out_adel  (out_adel),
    .count     (count)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [31:0] pc, input logic [31:0] instr);
    in_valid = 1'b1;
    in_pc    = pc;
    in_instr = instr;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = 32'h0; in_instr = 32'h0;
    tick(); tick();
    reset = 1'b0;

    check("rst_count", count, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_pc", out_pc, 0);

    // 1: fill then drain in order
    for (int i = 0; i < 4; i++) push_one(32'(4*i), 32'h2000_0000 + 32'(i));
    check("fill_count", count, 4);
    check("fill_in_ready", in_ready, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_pc", out_pc, 64'(4*i));
      check("drain_instr", out_instr, 64'(32'h2000_0000 + 32'(i)));
      check("drain_count", count, 64'(4-i));
      tick();
    end
    check("drain_out_valid", out_valid, 0);
    check("drain_count_end", count, 0);
    out_ready = 1'b0;

    // 2: steady push+pop at count 2 across pointer wrap
    push_one(32'h100, 32'h0);
    push_one(32'h104, 32'h0);
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_pc = 32'h108 + 32'(4*i); out_ready = 1'b1;
      check("flow_count", count, 2);
      check("flow_pc", out_pc, 64'(32'h100 + 32'(4*i)));
      tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("flow_tail_pc", out_pc, 64'(32'h120 + 32'(4*i)));
      tick();
    end
    out_ready = 1'b0;
    check("flow_end_count", count, 0);

    // 3: full with pop: push refused
    for (int i = 0; i < 4; i++) push_one(32'h200 + 32'(4*i), 32'h0);
    in_valid = 1'b1; in_pc = 32'h300; out_ready = 1'b1;
    check("fullpop_in_ready", in_ready, 0);
    check("fullpop_head", out_pc, 32'h200);
    tick();
    in_valid = 1'b0;
    check("fullpop_count", count, 3);
    check("fullpop_in_ready_next", in_ready, 1);
    for (int i = 0; i < 3; i++) begin
      check("fullpop_pc", out_pc, 64'(32'h204 + 32'(4*i)));
      tick();
    end
    check("fullpop_empty", out_valid, 0);
    out_ready = 1'b0;

    // 4: flush discards queue and the concurrent push
    for (int i = 0; i < 3; i++) push_one(32'h400 + 32'(4*i), 32'h0);
    check("pre_flush_count", count, 3);
    flush = 1'b1; in_valid = 1'b1; in_pc = 32'h500; out_ready = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    check("flush_count", count, 0);
    check("flush_out_valid", out_valid, 0);
    check("flush_out_pc", out_pc, 0);
    push_one(32'h40C, 32'h0);
    check("post_flush_head", out_pc, 32'h40C);
    check("post_flush_count", count, 1);
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    // 5: address errors
    push_one(32'h6, 32'h8C01_0000);
    check("adel_mis_flag", out_adel, 1);
    check("adel_mis_instr", out_instr, 0);
    check("adel_mis_pc", out_pc, 32'h6);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    push_one(32'h1_0000, 32'h8C01_0000);
    check("adel_range_flag", out_adel, 1);
    check("adel_range_instr", out_instr, 0);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    push_one(32'h3FFC, 32'h8C01_0000);
    check("adel_ok_flag", out_adel, 0);
    check("adel_ok_instr", out_instr, 32'h8C01_0000);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    check("adel_end_count", count, 0);

    // 6: reset mid-stream, then field split on next entry
    push_one(32'h600, 32'h0);
    push_one(32'h604, 32'h0);
    check("prerst_count", count, 2);
    reset = 1'b1; tick(); reset = 1'b0;
    check("midrst_count", count, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    push_one(32'h20, 32'h014B_4820);
    check("split_pc", out_pc, 32'h20);
    check("split_rs", out_rs, 10);
    check("split_rt", out_rt, 11);
    check("split_rd", out_rd, 9);
    check("split_imm16", out_imm16, 16'h4820);
    check("split_imm26", out_imm26, 26'h14B_4820);
    check("split_adel", out_adel, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
